lfsr_share_arbiter: RTL and testbench
=====================================

# lfsr_share_arbiter

Round-robin scheduler that shares one `custom_parallel_LFSR` instance (LFSR_N-bit, LFSR_M-word) among NUM_REQ requesters. Each requester asks for a burst of M-word random vectors; the block grants one requester at a time and streams LFSR output with a valid/ready handshake. It advances the LFSR once per accepted vector and sequences seed reloads between bursts. Sits between the LFSR instance and its consumers.

## Interface
- LFSR_N, 8, LFSR word width
- LFSR_M, 4, words per LFSR output vector
- NUM_REQ, 4, number of requesters (≥2)
- BURST_W, 4, width of per-requester burst-length field
- i_clk  in  1  clock; all logic rising-edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  NUM_REQ  per-requester request level
- i_req_len  in  NUM_REQ*BURST_W  burst length per requester, slice k = [k*BURST_W +: BURST_W]; 0 means 2^BURST_W
- i_ready  in  NUM_REQ  per-requester ready
- i_reseed_req  in  1  reseed request pulse
- i_reseed_val  in  LFSR_N  seed captured with i_reseed_req
- i_LFSR_val  in  LFSR_M*LFSR_N  current LFSR output vector
- o_LFSR_enable  out  1  LFSR advance/load enable
- o_LFSR_load  out  1  LFSR seed load
- o_LFSR_seed  out  LFSR_N  seed to LFSR, registered
- o_gnt  out  NUM_REQ  one-hot grant, registered
- o_data  out  LFSR_M*LFSR_N  equals i_LFSR_val (passthrough)
- o_data_valid  out  1  vector valid for granted requester
- o_done  out  NUM_REQ  one-cycle completion pulse, registered

## Operation
- States: IDLE, RESEED, STREAM.
- Reset: state IDLE, rr pointer = NUM_REQ-1 (requester 0 wins first), o_gnt=0, o_done=0, o_LFSR_seed=0, reseed pending=0, count=0. All outputs 0.
- Reseed capture (any state): i_reseed_req=1 sets pending and stores i_reseed_val; a later request overwrites the stored value.
- IDLE: if pending → RESEED. Else if any i_req → pick the first set bit after the pointer in circular order. Register o_gnt, move the pointer to the winner, load count with its length (0→2^BURST_W; count width BURST_W+1), go to STREAM. Else stay. Reseed has priority over grants.
- RESEED (one cycle): o_LFSR_load=1, o_LFSR_enable=1, o_LFSR_seed=stored value. Clear pending unless i_reseed_req is high the same cycle (pending stays, new value kept). Return to IDLE.
- STREAM: o_data_valid=1. A handshake is o_data_valid & i_ready[g], where g is the granted index. o_LFSR_enable = handshake (combinational from i_ready). Each handshake decrements count.
  - Handshake with count==1: go to IDLE, clear o_gnt, and set o_done[g] for the next cycle.
  - i_req[g]=0 with no handshake that cycle: abort. Go to IDLE, clear o_gnt, no o_done.
  - A handshake in the cycle i_req drops still counts; the abort takes effect the next cycle if words remain.
- Pending reseed never interrupts STREAM. It is serviced at the next IDLE.
- o_LFSR_load is 1 only in RESEED; o_LFSR_enable is 0 in IDLE.

## Timing
- i_req seen in IDLE at cycle t → o_gnt and o_data_valid high at t+1.
- One vector per cycle at full ready. The LFSR state after a handshake at t is visible on o_data at t+1.
- With ready low, o_data stays stable, since the LFSR does not advance.
- Final handshake at t → o_gnt=0 and o_done[g]=1 at t+1 (IDLE). The next grant is at t+2 earliest, a one-cycle gap.
- Reseed: pending at IDLE cycle t → RESEED at t+1 → IDLE at t+2 → earliest grant at t+3. The first streamed vector after that is the state loaded from the seed.
- Every delivered vector is followed by an advance, so no vector is delivered twice across grants.

## Test plan
- Reset with all inputs 0: every output 0. After release, with no request for 10 cycles, o_LFSR_enable and o_gnt stay 0.
- i_req=0001, len0=3, i_ready=1111: o_gnt=0001 one cycle later, 3 valid cycles, o_LFSR_enable high exactly 3 cycles. o_data matches 3 consecutive states of a bench LFSR model (P=8'h8E). Then o_done=0001 for one cycle.
- i_req=1011 held, all lengths 2, ready high: grant order 0,1,3,0,1,3. Each burst is 2 vectors, with one IDLE cycle between bursts.
- Backpressure on requester 1 with len=4 and i_ready[1] pattern 1,0,0,1,1,0,1: enable high only on ready cycles, o_data stable while ready=0, o_done[1] after the 4th handshake.
- i_reseed_req with 8'hC3 during the 2nd vector of a len-4 burst: the burst completes unchanged. Then one cycle with load=1, enable=1, seed=8'hC3. The next burst's first vector equals the LFSR state seeded with 8'hC3.
- i_req=0100, len2=0: expects 16 vectors. After 5 handshakes drop i_req[2] with ready=0: return to IDLE, no o_done. A pending i_req=0101 is then granted to 0, since the pointer has passed 2.

Source files
------------

// File: rtl/lfsr_share_arbiter.sv
// Round-robin scheduler sharing one parallel LFSR among NUM_REQ requesters.
// Streams one LFSR vector per handshake and sequences seed reloads between bursts.
module lfsr_share_arbiter #(
  parameter int unsigned LFSR_N  = 8,
  parameter int unsigned LFSR_M  = 4,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned BURST_W = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*BURST_W-1:0] i_req_len,
  input  logic [NUM_REQ-1:0]         i_ready,
  input  logic                       i_reseed_req,
  input  logic [LFSR_N-1:0]          i_reseed_val,
  input  logic [LFSR_M*LFSR_N-1:0]   i_LFSR_val,
  output logic                       o_LFSR_enable,
  output logic                       o_LFSR_load,
  output logic [LFSR_N-1:0]          o_LFSR_seed,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [LFSR_M*LFSR_N-1:0]   o_data,
  output logic                       o_data_valid,
  output logic [NUM_REQ-1:0]         o_done
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RESEED, STREAM} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [NUM_REQ-1:0] gnt, gnt_nxt;
  logic [NUM_REQ-1:0] done, done_nxt;
  logic [LFSR_N-1:0]  seed_q, seed_nxt;
  logic [LFSR_N-1:0]  seed_store, seed_store_nxt;
  logic               pending, pending_nxt;
  logic [BURST_W:0]   count, count_nxt;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand_idx;
  int unsigned        cand;
  logic [BURST_W-1:0] win_len;
  logic               handshake;

  // Circular search starting just after the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand     = (32'(rr_ptr) + i) % NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!win_found && i_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign win_len   = i_req_len[win_idx*BURST_W +: BURST_W];
  // In STREAM the pointer already holds the granted index.
  assign handshake = (state == STREAM) && i_ready[rr_ptr];

  always_comb begin
    state_nxt      = state;
    rr_ptr_nxt     = rr_ptr;
    gnt_nxt        = gnt;
    done_nxt       = '0;
    seed_nxt       = seed_q;
    seed_store_nxt = seed_store;
    pending_nxt    = pending;
    count_nxt      = count;
    o_LFSR_load    = 1'b0;
    o_LFSR_enable  = 1'b0;
    o_data_valid   = 1'b0;

    if (i_reseed_req) begin
      pending_nxt    = 1'b1;
      seed_store_nxt = i_reseed_val;
    end

    case (state)
      IDLE: begin
        if (pending) begin
          // A same-cycle reseed request supersedes the stored value.
          seed_nxt  = i_reseed_req ? i_reseed_val : seed_store;
          state_nxt = RESEED;
        end else if (win_found) begin
          gnt_nxt    = NUM_REQ'(1) << win_idx;
          rr_ptr_nxt = win_idx;
          count_nxt  = (win_len == '0) ? {1'b1, {BURST_W{1'b0}}} : {1'b0, win_len};
          state_nxt  = STREAM;
        end
      end
      RESEED: begin
        o_LFSR_load   = 1'b1;
        o_LFSR_enable = 1'b1;
        if (!i_reseed_req) pending_nxt = 1'b0;
        state_nxt = IDLE;
      end
      STREAM: begin
        o_data_valid  = 1'b1;
        o_LFSR_enable = handshake;
        if (handshake) begin
          count_nxt = count - 1'b1;
          if (count == (BURST_W+1)'(1)) begin
            gnt_nxt          = '0;
            done_nxt[rr_ptr] = 1'b1;
            state_nxt        = IDLE;
          end
        end else if (!i_req[rr_ptr]) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= PTR_W'(NUM_REQ - 1);
      gnt        <= '0;
      done       <= '0;
      seed_q     <= '0;
      seed_store <= '0;
      pending    <= 1'b0;
      count      <= '0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_ptr_nxt;
      gnt        <= gnt_nxt;
      done       <= done_nxt;
      seed_q     <= seed_nxt;
      seed_store <= seed_store_nxt;
      pending    <= pending_nxt;
      count      <= count_nxt;
    end
  end

  assign o_gnt       = gnt;
  assign o_done      = done;
  assign o_LFSR_seed = seed_q;
  assign o_data      = i_LFSR_val;

endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Directed bench for lfsr_share_arbiter with a Galois LFSR (P=8'h8E) behind it
// and a scoreboard of expected vectors consumed at each handshake.
module tb_lfsr_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [3:0]  ready;
  logic        reseed_req;
  logic [7:0]  reseed_val;
  logic [31:0] lfsr_val;
  logic        o_LFSR_enable, o_LFSR_load, o_data_valid;
  logic [7:0]  o_LFSR_seed;
  logic [3:0]  o_gnt, o_done;
  logic [31:0] o_data;

  int n_cmp = 0;
  int n_err = 0;
  int en_cnt = 0;
  logic [7:0]  exp_state;
  logic [31:0] sb[$];
  logic [7:0]  lfsr_q;

  lfsr_share_arbiter #(.LFSR_N(8), .LFSR_M(4), .NUM_REQ(4), .BURST_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_len(req_len), .i_ready(ready),
    .i_reseed_req(reseed_req), .i_reseed_val(reseed_val), .i_LFSR_val(lfsr_val),
    .o_LFSR_enable(o_LFSR_enable), .o_LFSR_load(o_LFSR_load), .o_LFSR_seed(o_LFSR_seed),
    .o_gnt(o_gnt), .o_data(o_data), .o_data_valid(o_data_valid), .o_done(o_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] step8(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'h8E) : (s >> 1);
  endfunction

  function automatic logic [31:0] vec(input logic [7:0] s);
    logic [31:0] v;
    logic [7:0]  w;
    w = s;
    for (int k = 0; k < 4; k++) begin
      v[k*8 +: 8] = w;
      w = step8(w);
    end
    return v;
  endfunction

  function automatic logic [7:0] adv(input logic [7:0] s);
    logic [7:0] w;
    w = s;
    for (int k = 0; k < 4; k++) w = step8(w);
    return w;
  endfunction

  // The shared LFSR the arbiter drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             lfsr_q <= 8'h01;
    else if (o_LFSR_enable) lfsr_q <= o_LFSR_load ? o_LFSR_seed : adv(lfsr_q);
  end
  assign lfsr_val = vec(lfsr_q);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(vec(exp_state));
      exp_state = adv(exp_state);
    end
  endtask

  task automatic monitor();
    logic hs;
    hs = o_data_valid && ((o_gnt & ready) != 4'b0);
    if (o_LFSR_enable) en_cnt++;
    chk("lfsr_enable", 64'(o_LFSR_enable), 64'(hs | o_LFSR_load));
    if (hs) begin
      if (sb.size() == 0) chk("sb_depth", 64'(sb.size()), 64'd1);
      else chk("data", 64'(o_data), 64'(sb.pop_front()));
    end
  endtask

  task automatic clk_step();
    #1;
    monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; ready = '0; req_len = '0; reseed_req = 1'b0; reseed_val = '0;
    exp_state = 8'h01;
    sb.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  int order[6] = '{0, 1, 3, 0, 1, 3};
  int pat[7]   = '{1, 0, 0, 1, 1, 0, 1};
  logic [31:0] prev_data;

  initial begin
    rst_n = 1'b0;
    req = '0; ready = '0; req_len = '0; reseed_req = 1'b0; reseed_val = '0;
    exp_state = 8'h01;
    #3;
    chk("rst_gnt", 64'(o_gnt), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_en", 64'(o_LFSR_enable), 64'd0);
    chk("rst_load", 64'(o_LFSR_load), 64'd0);
    chk("rst_seed", 64'(o_LFSR_seed), 64'd0);
    chk("rst_valid", 64'(o_data_valid), 64'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_gnt", 64'(o_gnt), 64'd0);
      clk_step();
    end
    chk("idle_en_count", 64'(en_cnt), 64'd0);

    // Single burst of 3 for requester 0
    en_cnt = 0;
    req = 4'b0001; req_len = 16'h0003; ready = 4'hF;
    push_n(3);
    chk("b3_gnt_pre", 64'(o_gnt), 64'd0);
    clk_step();
    chk("b3_gnt", 64'(o_gnt), 64'h1);
    chk("b3_valid", 64'(o_data_valid), 64'd1);
    clk_step();
    clk_step();
    req = 4'b0000;
    clk_step();
    chk("b3_gnt_end", 64'(o_gnt), 64'd0);
    chk("b3_done", 64'(o_done), 64'h1);
    chk("b3_valid_end", 64'(o_data_valid), 64'd0);
    clk_step();
    chk("b3_done_pulse", 64'(o_done), 64'd0);
    chk("b3_en_count", 64'(en_cnt), 64'd3);

    // Round robin among 0,1,3
    do_reset();
    req = 4'b1011; req_len = 16'h2222; ready = 4'hF;
    push_n(2);
    clk_step();
    for (int b = 0; b < 6; b++) begin
      chk("rr_gnt", 64'(o_gnt), 64'(1 << order[b]));
      clk_step();
      clk_step();
      chk("rr_gap_gnt", 64'(o_gnt), 64'd0);
      chk("rr_done", 64'(o_done), 64'(1 << order[b]));
      if (b == 5) req = 4'b0000;
      else push_n(2);
      clk_step();
    end

    // Backpressure on requester 1
    en_cnt = 0;
    req = 4'b0010; req_len = 16'h0040; ready = 4'h0;
    push_n(4);
    clk_step();
    prev_data = o_data;
    for (int i = 0; i < 7; i++) begin
      ready = {2'b00, pat[i][0], 1'b0};
      if (i == 6) req = 4'b0000;
      chk("bp_gnt", 64'(o_gnt), 64'h2);
      chk("bp_done", 64'(o_done), 64'd0);
      if (i > 0 && pat[i-1] == 0) chk("bp_stable", 64'(o_data), 64'(prev_data));
      prev_data = o_data;
      clk_step();
    end
    chk("bp_done_end", 64'(o_done), 64'h2);
    chk("bp_en_count", 64'(en_cnt), 64'd4);

    // Reseed request during a burst
    req = 4'b0001; req_len = 16'h0004; ready = 4'hF;
    push_n(4);
    clk_step();
    chk("rs_gnt", 64'(o_gnt), 64'h1);
    clk_step();
    reseed_req = 1'b1; reseed_val = 8'hC3;
    clk_step();
    reseed_req = 1'b0; reseed_val = 8'h00;
    clk_step();
    req = 4'b0000;
    clk_step();
    chk("rs_done", 64'(o_done), 64'h1);
    chk("rs_load_idle", 64'(o_LFSR_load), 64'd0);
    req = 4'b0001; req_len = 16'h0002;
    clk_step();
    chk("rs_load", 64'(o_LFSR_load), 64'd1);
    chk("rs_en", 64'(o_LFSR_enable), 64'd1);
    chk("rs_seed", 64'(o_LFSR_seed), 64'hC3);
    chk("rs_gnt_hold", 64'(o_gnt), 64'd0);
    exp_state = 8'hC3;
    push_n(2);
    clk_step();
    chk("rs_load_off", 64'(o_LFSR_load), 64'd0);
    chk("rs_gnt_gap", 64'(o_gnt), 64'd0);
    clk_step();
    chk("rs_gnt2", 64'(o_gnt), 64'h1);
    clk_step();
    req = 4'b0000;
    clk_step();
    chk("rs_done2", 64'(o_done), 64'h1);

    // Max-length burst aborted after 5 handshakes
    req = 4'b0100; req_len = 16'h0000; ready = 4'hF;
    push_n(5);
    clk_step();
    for (int i = 0; i < 5; i++) begin
      chk("ab_gnt", 64'(o_gnt), 64'h4);
      clk_step();
    end
    req = 4'b0000; ready = 4'h0;
    chk("ab_valid", 64'(o_data_valid), 64'd1);
    clk_step();
    chk("ab_gnt_end", 64'(o_gnt), 64'd0);
    chk("ab_no_done", 64'(o_done), 64'd0);
    chk("ab_valid_end", 64'(o_data_valid), 64'd0);
    req = 4'b0101; req_len = 16'h0001; ready = 4'hF;
    push_n(1);
    clk_step();
    chk("ab_next_gnt", 64'(o_gnt), 64'h1);
    chk("ab_no_done2", 64'(o_done), 64'd0);
    req = 4'b0000;
    clk_step();
    chk("ab_next_done", 64'(o_done), 64'h1);

    // Full 16-vector burst (length field 0)
    req = 4'b1000; req_len = 16'h0000; ready = 4'hF;
    push_n(16);
    clk_step();
    for (int i = 0; i < 16; i++) begin
      chk("l16_gnt", 64'(o_gnt), 64'h8);
      chk("l16_done", 64'(o_done), 64'd0);
      if (i == 15) req = 4'b0000;
      clk_step();
    end
    chk("l16_done_end", 64'(o_done), 64'h8);
    chk("l16_gnt_end", 64'(o_gnt), 64'd0);
    clk_step();
    chk("sb_final_depth", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
